// File: rtl/elastic_pkg.sv
// Shared definitions for the elastic (data/valid/ready) component family:
// default payload width and the channel record used by join/fork/buffers.
package elastic_pkg;

  localparam int ELASTIC_DATA_WIDTH = 32;

  typedef struct packed {
    logic [ELASTIC_DATA_WIDTH-1:0] data;
    logic                          v;
  } elastic_ch_t;

endpackage : elastic_pkg

// File: rtl/elastic_fork_branch.sv
// One output branch of the eager fork: remembers whether this branch has
// already taken the current token and reports when it no longer blocks the input.
module elastic_fork_branch
  import elastic_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din_v_i,
  input  logic en_i,
  input  logic dout_r_i,
  input  logic consume_i,
  output logic dout_v_o,
  output logic done_o
);

  logic sent_q;
  logic sent_d;

  assign dout_v_o = din_v_i & en_i & ~sent_q;
  assign done_o   = ~en_i | sent_q | dout_r_i;

  // Clear on input consume so the next token starts clean; otherwise latch a branch handshake.
  always_comb begin
    sent_d = sent_q;
    if (consume_i) begin
      sent_d = 1'b0;
    end else if (dout_v_o & dout_r_i) begin
      sent_d = 1'b1;
    end else begin
      sent_d = sent_q;
    end
  end

  // Sent-flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_q <= 1'b0;
    end else begin
      sent_q <= sent_d;
    end
  end

endmodule : elastic_fork_branch

// File: rtl/elastic_eager_fork.sv
// Eager fork: broadcasts one elastic stream to NUM_OUTPUTS branches, each taking the
// token in its own cycle. Optional consumed-token counter via `ELASTIC_FORK_CNT_EN.
module elastic_eager_fork
  import elastic_pkg::*;
#(
  parameter int DATA_WIDTH  = ELASTIC_DATA_WIDTH,
  parameter int NUM_OUTPUTS = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic                   din_v,
  output logic                   din_r,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic [NUM_OUTPUTS-1:0] dout_v,
  input  logic [NUM_OUTPUTS-1:0] dout_r,
  input  logic [NUM_OUTPUTS-1:0] fork_mask
`ifdef ELASTIC_FORK_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]   token_cnt
`endif
);

  logic [NUM_OUTPUTS-1:0] done_s;
  logic                   consume_s;

  if (NUM_OUTPUTS < 1 || CNT_WIDTH < 1) begin : g_param_check
    $error("elastic_eager_fork: NUM_OUTPUTS and CNT_WIDTH must be >= 1");
  end

  assign dout      = din;
  assign din_r     = &done_s;
  assign consume_s = din_v & din_r;

  for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_branch
    elastic_fork_branch u_branch (
      .clk       (clk),
      .rst_n     (rst_n),
      .din_v_i   (din_v),
      .en_i      (fork_mask[i]),
      .dout_r_i  (dout_r[i]),
      .consume_i (consume_s),
      .dout_v_o  (dout_v[i]),
      .done_o    (done_s[i])
    );
  end

`ifdef ELASTIC_FORK_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Count every input handshake, sunk tokens included; wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (consume_s) begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Token counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign token_cnt = cnt_q;
`endif

endmodule : elastic_eager_fork

// File: tb/tb_elastic_eager_fork.sv
// Directed + randomized bench for elastic_eager_fork; reference model tracks which
// token index each branch last received and per-branch delivery queues.
module tb_elastic_eager_fork;

  localparam int DW = 32;
  localparam int NO = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          din_v;
  logic          din_r;
  logic [NO-1:0] dout_v;
  logic [NO-1:0] dout_r;
  logic [NO-1:0] fork_mask;
`ifdef ELASTIC_FORK_CNT_EN
  logic [CW-1:0] token_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int in_cnt = 0;
  int exp_cnt = 0;
  int got_idx [NO];
  logic [DW-1:0] rcvq [NO][$];
  logic [DW-1:0] tok [$];
  logic          obs_r;

  always #5 clk = ~clk;

  elastic_eager_fork #(
    .DATA_WIDTH  (DW),
    .NUM_OUTPUTS (NO),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_v     (din_v),
    .din_r     (din_r),
    .dout      (dout),
    .dout_v    (dout_v),
    .dout_r    (dout_r),
    .fork_mask (fork_mask)
`ifdef ELASTIC_FORK_CNT_EN
    ,
    .token_cnt (token_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // A branch is owed the current token unless it already received token number in_cnt.
  function automatic logic [NO-1:0] exp_dv();
    logic [NO-1:0] r;
    for (int i = 0; i < NO; i++)
      r[i] = din_v & fork_mask[i] & (got_idx[i] != in_cnt);
    return r;
  endfunction

  function automatic logic exp_dr();
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NO; i++)
      if (fork_mask[i] && got_idx[i] != in_cnt && !dout_r[i]) ok = 1'b0;
    return ok;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".dout_v"}, 64'(dout_v), 64'(exp_dv()));
    chk({tag, ".din_r"}, 64'(din_r), 64'(exp_dr()));
`ifdef ELASTIC_FORK_CNT_EN
    chk({tag, ".token_cnt"}, 64'(token_cnt), 64'(exp_cnt));
`endif
  endtask

  task automatic cyc(input string tag, input logic v, input logic [DW-1:0] d, input logic [NO-1:0] r);
    logic [NO-1:0] sv;
    logic [DW-1:0] sd;
    din_v = v; din = d; dout_r = r;
    #2;
    check_outputs(tag);
    if (v) chk({tag, ".dout"}, 64'(dout), 64'(d));
    sv = dout_v; sd = dout; obs_r = din_r;
    @(posedge clk);
    for (int i = 0; i < NO; i++)
      if (sv[i] && r[i]) begin
        rcvq[i].push_back(sd);
        got_idx[i] = in_cnt;
      end
    if (v && obs_r) begin
      in_cnt++;
      exp_cnt = (exp_cnt + 1) % (1 << CW);
    end
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NO; i++) got_idx[i] = -1;
    exp_cnt = 0;
  endtask

  initial begin
    logic          v;
    logic          pend;
    logic [DW-1:0] d;
    int            base;
    rst_n = 1'b0; din = '0; din_v = 1'b0; dout_r = '0; fork_mask = 2'b11;
    model_reset();
    #2;
    check_outputs("reset");
    din_v = 1'b1;
    #1;
    check_outputs("reset_valid");
    din_v = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: all branches ready together
    cyc("t1", 1'b1, 32'hA5, 2'b11);
    cyc("t1_next", 1'b1, 32'h11, 2'b00);
    cyc("t1_drain", 1'b1, 32'h11, 2'b11);

    // 2: branches accept in different cycles
    cyc("t2_c0", 1'b1, 32'h22, 2'b01);
    cyc("t2_c1", 1'b1, 32'h22, 2'b10);
    cyc("t2_c2", 1'b1, 32'h23, 2'b00);
    cyc("t2_drain", 1'b1, 32'h23, 2'b11);
    cyc("idle", 1'b0, 32'h0, 2'b11);

    // 3: only branch 1 enabled
    fork_mask = 2'b10;
    cyc("t3_c0", 1'b1, 32'h33, 2'b00);
    cyc("t3_c1", 1'b1, 32'h33, 2'b01);
    cyc("t3_c2", 1'b1, 32'h33, 2'b10);
    cyc("idle", 1'b0, 32'h0, 2'b00);

    // 4: discard mode
    fork_mask = 2'b00;
    for (int k = 0; k < 5; k++) cyc("t4", 1'b1, DW'(k), 2'b00);
    cyc("idle", 1'b0, 32'h0, 2'b00);

    // 5: reset with a partially delivered token
    fork_mask = 2'b11;
    cyc("t5_b0", 1'b1, 32'h55, 2'b01);
    din_v = 1'b1; dout_r = 2'b00; rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("t5_in_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("t5_after", 1'b1, 32'h55, 2'b11);

    // 6: random back-pressure, each branch must see every token once, in order
    base = in_cnt;
    for (int i = 0; i < NO; i++) rcvq[i].delete();
    for (int k = 0; k < 17; k++) tok.push_back($urandom);
    pend = 1'b0;
    for (int c = 0; c < 600 && (in_cnt - base) < 17; c++) begin
      v = pend ? 1'b1 : ($urandom_range(0, 3) != 0);
      d = v ? tok[in_cnt - base] : DW'($urandom);
      cyc("t6", v, d, NO'($urandom));
      pend = v & ~obs_r;
    end
    chk("t6_tokens", 64'(in_cnt - base), 64'd17);
    for (int i = 0; i < NO; i++) begin
      chk("t6_qsize", 64'(rcvq[i].size()), 64'd17);
      for (int k = 0; k < rcvq[i].size() && k < 17; k++)
        chk("t6_order", 64'(rcvq[i][k]), 64'(tok[k]));
    end
    cyc("t6_idle", 1'b0, 32'h0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_elastic_eager_fork
